// File: rtl/master_out_port_mw.sv
// Multi-lane serial-bus master output port: arbitrates for the bus, then
// streams slave address, burst length and write words LANES bits per cycle.
module master_out_port_mw #(
  parameter int unsigned WORD_SIZE       = 8,
  parameter int unsigned BURST_SIZE      = 12,
  parameter int unsigned SLAVE_NO        = 3,
  parameter int unsigned SLAVE_ADDR_SIZE = 12,
  parameter int unsigned LANES           = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [2:0]                   instruction,
  input  logic [BURST_SIZE-1:0]        burst_size,
  input  logic [WORD_SIZE-1:0]         m_data,
  input  logic [SLAVE_ADDR_SIZE-1:0]   s_addr,
  input  logic [$clog2(SLAVE_NO)-1:0]  slave_id,
  input  logic [SLAVE_NO-1:0]          s_ready,
  input  logic                         bus_grant,
  input  logic                         split_en,
  output logic                         bus_req,
  output logic [LANES-1:0]             addr_bus,
  output logic [LANES-1:0]             burst_size_bus,
  output logic [LANES-1:0]             w_data_bus,
  output logic                         m_valid,
  output logic                         read_en,
  output logic                         write_en,
  output logic [SLAVE_NO-1:0]          slave_select,
  output logic                         addr_done,
  output logic                         burst_done,
  output logic                         tx_done,
  output logic                         new_data,
  output logic                         bus_util,
  output logic                         split_on
);

  localparam int unsigned SID_W     = $clog2(SLAVE_NO);
  localparam int unsigned LANES_NZ  = (LANES == 0) ? 1 : LANES;
  localparam int unsigned FIELD_W   = (SLAVE_ADDR_SIZE > BURST_SIZE) ? SLAVE_ADDR_SIZE : BURST_SIZE;
  localparam int unsigned A_BEATS   = FIELD_W / LANES_NZ;
  localparam int unsigned W_BEATS   = WORD_SIZE / LANES_NZ;
  localparam int unsigned MAX_BEATS = (A_BEATS > W_BEATS) ? A_BEATS : W_BEATS;
  localparam int unsigned CNT_W     = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

  // Reject lane widths that do not tile every serialised field exactly
  if (LANES == 0 || (WORD_SIZE % LANES_NZ) != 0 || (BURST_SIZE % LANES_NZ) != 0 ||
      (SLAVE_ADDR_SIZE % LANES_NZ) != 0) begin : g_cfg_err
    $error("master_out_port_mw: LANES must divide WORD_SIZE, BURST_SIZE and SLAVE_ADDR_SIZE");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_ADDR, S_WAIT, S_DATA, S_DONE, S_SPLIT
  } state_t;

  state_t                 state_q, state_n;
  logic [CNT_W-1:0]       beat_q, beat_n;
  logic [BURST_SIZE-1:0]  word_q, word_n, len_q, len_n;
  logic [FIELD_W-1:0]     addr_q, addr_n;
  logic [WORD_SIZE-1:0]   cur_q, cur_n;
  logic [SID_W-1:0]       sid_q, sid_n;
  logic                   is_rd_q, is_rd_n, is_burst_q, is_burst_n;
  logic                   skip_q, skip_n, reuse_q, reuse_n;

  logic                   bus_req_n, m_valid_n, read_en_n, write_en_n;
  logic                   addr_done_n, burst_done_n, tx_done_n, new_data_n, bus_util_n, split_on_n;
  logic [LANES-1:0]       addr_bus_n, burst_size_bus_n, w_data_bus_n;
  logic [SLAVE_NO-1:0]    slave_select_n;
  logic [FIELD_W-1:0]     addr_sh, len_sh;
  logic [WORD_SIZE-1:0]   data_sh;
  logic                   active_n;

  // State, datapath and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      beat_q         <= '0;
      word_q         <= '0;
      len_q          <= '0;
      addr_q         <= '0;
      cur_q          <= '0;
      sid_q          <= '0;
      is_rd_q        <= 1'b0;
      is_burst_q     <= 1'b0;
      skip_q         <= 1'b0;
      reuse_q        <= 1'b0;
      bus_req        <= 1'b0;
      addr_bus       <= '0;
      burst_size_bus <= '0;
      w_data_bus     <= '0;
      m_valid        <= 1'b0;
      read_en        <= 1'b0;
      write_en       <= 1'b0;
      slave_select   <= '0;
      addr_done      <= 1'b0;
      burst_done     <= 1'b0;
      tx_done        <= 1'b0;
      new_data       <= 1'b0;
      bus_util       <= 1'b0;
      split_on       <= 1'b0;
    end else begin
      state_q        <= state_n;
      beat_q         <= beat_n;
      word_q         <= word_n;
      len_q          <= len_n;
      addr_q         <= addr_n;
      cur_q          <= cur_n;
      sid_q          <= sid_n;
      is_rd_q        <= is_rd_n;
      is_burst_q     <= is_burst_n;
      skip_q         <= skip_n;
      reuse_q        <= reuse_n;
      bus_req        <= bus_req_n;
      addr_bus       <= addr_bus_n;
      burst_size_bus <= burst_size_bus_n;
      w_data_bus     <= w_data_bus_n;
      m_valid        <= m_valid_n;
      read_en        <= read_en_n;
      write_en       <= write_en_n;
      slave_select   <= slave_select_n;
      addr_done      <= addr_done_n;
      burst_done     <= burst_done_n;
      tx_done        <= tx_done_n;
      new_data       <= new_data_n;
      bus_util       <= bus_util_n;
      split_on       <= split_on_n;
    end
  end

  // Next state, datapath updates and next-cycle output values
  always_comb begin
    state_n    = state_q;
    beat_n     = beat_q;
    word_n     = word_q;
    len_n      = len_q;
    addr_n     = addr_q;
    cur_n      = cur_q;
    sid_n      = sid_q;
    is_rd_n    = is_rd_q;
    is_burst_n = is_burst_q;
    skip_n     = skip_q;
    reuse_n    = reuse_q;
    new_data_n = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (instruction inside {3'b001, 3'b010, 3'b011, 3'b100}) begin
          is_rd_n    = (instruction == 3'b010) || (instruction == 3'b100);
          is_burst_n = (instruction == 3'b011) || (instruction == 3'b100);
          len_n      = (is_burst_n && (burst_size != '0)) ? burst_size : BURST_SIZE'(1);
          addr_n     = FIELD_W'(s_addr);
          sid_n      = slave_id;
          word_n     = '0;
          beat_n     = '0;
          skip_n     = 1'b0;
          reuse_n    = 1'b0;
          state_n    = S_REQ;
        end
      end
      S_REQ: begin
        if (bus_grant) begin
          beat_n  = '0;
          state_n = skip_q ? S_WAIT : S_ADDR;
        end
      end
      S_ADDR: begin
        if (!bus_grant && !split_en) state_n = S_IDLE;
        else if (beat_q == CNT_W'(A_BEATS - 1)) state_n = S_WAIT;
        else beat_n = beat_q + CNT_W'(1);
      end
      S_WAIT: begin
        if (split_en) begin
          skip_n  = 1'b1;
          state_n = S_SPLIT;
        end else if (!bus_grant) begin
          state_n = S_IDLE;
        end else if (s_ready[sid_q]) begin
          if (is_rd_q) begin
            state_n = S_DONE;
          end else begin
            // A resumed word replays the saved copy instead of consuming m_data
            if (!reuse_q) begin
              cur_n      = m_data;
              new_data_n = 1'b1;
            end
            reuse_n = 1'b0;
            beat_n  = '0;
            state_n = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (split_en) begin
          skip_n  = 1'b1;
          reuse_n = 1'b1;
          state_n = S_SPLIT;
        end else if (!bus_grant) begin
          state_n = S_IDLE;
        end else if (beat_q == CNT_W'(W_BEATS - 1)) begin
          if (word_q == len_q - BURST_SIZE'(1)) begin
            state_n = S_DONE;
          end else begin
            word_n     = word_q + BURST_SIZE'(1);
            cur_n      = m_data;
            new_data_n = 1'b1;
            beat_n     = '0;
          end
        end else begin
          beat_n = beat_q + CNT_W'(1);
        end
      end
      S_DONE:  state_n = S_IDLE;
      S_SPLIT: if (!split_en) state_n = S_REQ;
      default: state_n = S_IDLE;
    endcase

    active_n       = (state_n != S_IDLE);
    bus_req_n      = active_n && (state_n != S_SPLIT);
    bus_util_n     = state_n inside {S_ADDR, S_WAIT, S_DATA, S_DONE};
    m_valid_n      = state_n inside {S_ADDR, S_DATA};
    read_en_n      = active_n && is_rd_n;
    write_en_n     = active_n && !is_rd_n;
    slave_select_n = active_n ? (SLAVE_NO'(1) << sid_n) : '0;
    split_on_n     = (state_n == S_SPLIT);
    tx_done_n      = (state_n == S_DONE);
    addr_done_n    = (state_n == S_ADDR) && (beat_n == CNT_W'(A_BEATS - 1));
    burst_done_n   = (state_n == S_DATA) && is_burst_n && (beat_n == CNT_W'(W_BEATS - 1)) &&
                     (word_n == len_n - BURST_SIZE'(1));

    addr_sh          = addr_n >> (LANES * 32'(beat_n));
    len_sh           = FIELD_W'(len_n) >> (LANES * 32'(beat_n));
    data_sh          = cur_n >> (LANES * 32'(beat_n));
    addr_bus_n       = (state_n == S_ADDR) ? addr_sh[LANES-1:0] : '0;
    burst_size_bus_n = (state_n == S_ADDR) ? len_sh[LANES-1:0]  : '0;
    w_data_bus_n     = (state_n == S_DATA) ? data_sh[LANES-1:0] : '0;
  end

endmodule

// File: tb/tb_master_out_port_mw.sv
// Directed bench: one LANES=1 and one LANES=4 instance share the stimulus;
// a posedge recorder rebuilds the serial streams of the selected instance.
module tb_master_out_port_mw;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  instruction = '0;
  logic [11:0] burst_size = '0;
  logic [7:0]  m_data;
  logic [11:0] s_addr = '0;
  logic [1:0]  slave_id = '0;
  logic [2:0]  s_ready = '0;
  logic        bus_grant = 1'b0;
  logic        split_en = 1'b0;

  always #5 clk = ~clk;

  logic       br1, mv1, rd1, wr1, ad1, bd1, td1, nd1, bu1, so1, a1, b1, w1;
  logic [2:0] ss1;
  logic       br4, mv4, rd4, wr4, ad4, bd4, td4, nd4, bu4, so4;
  logic [3:0] a4, b4, w4;
  logic [2:0] ss4;

  master_out_port_mw #(.LANES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .instruction(instruction), .burst_size(burst_size),
    .m_data(m_data), .s_addr(s_addr), .slave_id(slave_id), .s_ready(s_ready),
    .bus_grant(bus_grant), .split_en(split_en), .bus_req(br1), .addr_bus(a1),
    .burst_size_bus(b1), .w_data_bus(w1), .m_valid(mv1), .read_en(rd1), .write_en(wr1),
    .slave_select(ss1), .addr_done(ad1), .burst_done(bd1), .tx_done(td1),
    .new_data(nd1), .bus_util(bu1), .split_on(so1));

  master_out_port_mw #(.LANES(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .instruction(instruction), .burst_size(burst_size),
    .m_data(m_data), .s_addr(s_addr), .slave_id(slave_id), .s_ready(s_ready),
    .bus_grant(bus_grant), .split_en(split_en), .bus_req(br4), .addr_bus(a4),
    .burst_size_bus(b4), .w_data_bus(w4), .m_valid(mv4), .read_en(rd4), .write_en(wr4),
    .slave_select(ss4), .addr_done(ad4), .burst_done(bd4), .tx_done(td4),
    .new_data(nd4), .bus_util(bu4), .split_on(so4));

  logic [31:0] outs1, outs4;
  assign outs1 = 32'({br1, a1, b1, w1, mv1, rd1, wr1, ss1, ad1, bd1, td1, nd1, bu1, so1});
  assign outs4 = 32'({br4, a4, b4, w4, mv4, rd4, wr4, ss4, ad4, bd4, td4, nd4, bu4, so4});

  // Selected-instance view for the recorder
  logic       sel = 1'b0;
  logic [3:0] mo_a, mo_b, mo_w;
  logic       mo_mv, mo_rd, mo_wr, mo_ad, mo_bd, mo_td, mo_nd, mo_bu, mo_so;
  always_comb begin
    mo_a  = sel ? a4 : {3'b000, a1};
    mo_b  = sel ? b4 : {3'b000, b1};
    mo_w  = sel ? w4 : {3'b000, w1};
    mo_mv = sel ? mv4 : mv1;
    mo_rd = sel ? rd4 : rd1;
    mo_wr = sel ? wr4 : wr1;
    mo_ad = sel ? ad4 : ad1;
    mo_bd = sel ? bd4 : bd1;
    mo_td = sel ? td4 : td1;
    mo_nd = sel ? nd4 : nd1;
    mo_bu = sel ? bu4 : bu1;
    mo_so = sel ? so4 : so1;
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Recorder state (written only by the recorder process)
  logic [7:0]  words [3];
  int          mon_req = 0, mon_ack = 0;
  logic        mon_en = 1'b0;
  int          cyc, na, nd, n_new, n_tx, tx_cyc, ad_cyc, bd_cyc, res_cyc, widx, lw, wb;
  logic [63:0] addr_s, bs_s, data_s;
  logic        addr_seen, split_seen, wnz, rd_bad, wr_seen;

  // Rebuild the LSB-first streams and feed words on new_data
  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      if (mon_req != mon_ack) begin
        mon_ack = mon_req;
        cyc = 0; na = 0; nd = 0; n_new = 0; n_tx = 0; tx_cyc = 0; ad_cyc = 0;
        bd_cyc = 0; res_cyc = 0; widx = 0;
        addr_s = '0; bs_s = '0; data_s = '0;
        addr_seen = 1'b0; split_seen = 1'b0; wnz = 1'b0; rd_bad = 1'b0; wr_seen = 1'b0;
        lw = sel ? 4 : 1;
        wb = 8 / lw;
        m_data = words[0];
      end
      cyc++;
      if (mo_so) begin
        split_seen = 1'b1;
        nd = (nd / wb) * wb;
        data_s = data_s & ((64'd1 << (nd * lw)) - 64'd1);
      end
      if (mo_mv && !addr_seen) begin
        addr_s = addr_s | (64'(mo_a) << (na * lw));
        bs_s   = bs_s | (64'(mo_b) << (na * lw));
        na++;
      end else if (mo_mv) begin
        data_s = data_s | (64'(mo_w) << (nd * lw));
        nd++;
        if (split_seen && res_cyc == 0) res_cyc = cyc;
      end
      if (mo_ad) begin addr_seen = 1'b1; ad_cyc = cyc; end
      if (mo_nd) begin
        n_new++;
        if (widx < 2) widx++;
        m_data = words[widx];
      end
      if (mo_bd) bd_cyc = cyc;
      if (mo_td) begin n_tx++; tx_cyc = cyc; end
      if (mo_w != 4'd0) wnz = 1'b1;
      if (mo_bu && !mo_rd) rd_bad = 1'b1;
      if (mo_wr) wr_seen = 1'b1;
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    instruction = '0; burst_size = '0; s_addr = '0; slave_id = '0; s_ready = '0;
    bus_grant = 1'b0; split_en = 1'b0; mon_en = 1'b0;
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic issue(input logic [2:0] ins, input logic [11:0] bsz, input logic [11:0] addr,
                       input logic [1:0] sid);
    instruction = ins; burst_size = bsz; s_addr = addr; slave_id = sid;
    tick();
    instruction = 3'b000;
  endtask

  // Called on the negedge where grant goes high; that grant edge is cycle 1
  task automatic start_mon(input logic s4);
    sel = s4;
    mon_req++;
    mon_en = 1'b1;
    bus_grant = 1'b1;
  endtask

  task automatic wait_tx(input int limit);
    for (int i = 0; i < limit; i++) begin
      tick();
      if (n_tx != 0) break;
    end
  endtask

  task automatic wait_cyc(input int target);
    for (int i = 0; i < 40; i++) begin
      tick();
      if (cyc >= target) break;
    end
  endtask

  initial begin
    words[0] = 8'hA9; words[1] = 8'hB9; words[2] = 8'hAF;
    tick();

    // 1: reset clears everything; idle instruction never requests
    rst_n = 1'b0;
    tick(); tick();
    check("t1_reset_outs1", 64'(outs1), 64'd0);
    check("t1_reset_outs4", 64'(outs4), 64'd0);
    rst_n = 1'b1; bus_grant = 1'b1;
    repeat (3) tick();
    check("t1_idle_no_req", 64'({br1, br4}), 64'd0);

    // 2: single write, LANES=1, grant two cycles late
    do_reset();
    s_ready = 3'b001;
    issue(3'b001, 12'd0, 12'h005, 2'd0);
    check("t2_req", 64'(br1), 64'd1);
    tick(); tick();
    check("t2_no_util_in_req", 64'(bu1), 64'd0);
    start_mon(1'b0);
    wait_tx(40);
    tick();
    check("t2_addr_beats", 64'(na), 64'd12);
    check("t2_addr", addr_s, 64'h005);
    check("t2_burst_field", bs_s, 64'h001);
    check("t2_data", data_s, 64'hA9);
    check("t2_data_beats", 64'(nd), 64'd8);
    check("t2_new_data", 64'(n_new), 64'd1);
    check("t2_addr_done_cyc", 64'(ad_cyc), 64'd12);
    check("t2_tx_done_cyc", 64'(tx_cyc), 64'd22);
    check("t2_no_burst_done", 64'(bd_cyc), 64'd0);
    check("t2_back_idle", 64'({br1, bu1, wr1}), 64'd0);

    // 3: burst write of three words, LANES=4
    do_reset();
    s_ready = 3'b001;
    issue(3'b011, 12'd3, 12'h3C5, 2'd0);
    start_mon(1'b1);
    wait_tx(40);
    tick();
    check("t3_addr_beats", 64'(na), 64'd3);
    check("t3_addr", addr_s, 64'h3C5);
    check("t3_burst_field", bs_s, 64'h003);
    check("t3_data", data_s, 64'hAFB9A9);
    check("t3_data_beats", 64'(nd), 64'd6);
    check("t3_new_data", 64'(n_new), 64'd3);
    check("t3_burst_done_cyc", 64'(bd_cyc), 64'd10);
    check("t3_tx_done_cyc", 64'(tx_cyc), 64'd11);

    // 4: burst read with length 0, slave ready 5 cycles after addr_done
    do_reset();
    slave_id = 2'd2;
    issue(3'b100, 12'd0, 12'h0A7, 2'd2);
    check("t4_select_req", 64'({ss4, rd4, wr4}), 64'b10010);
    start_mon(1'b1);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ad_cyc != 0) break;
    end
    repeat (5) tick();
    s_ready = 3'b100;
    wait_tx(10);
    tick();
    check("t4_addr", addr_s, 64'h0A7);
    check("t4_burst_field", bs_s, 64'h001);
    check("t4_tx_done_cyc", 64'(tx_cyc), 64'd9);
    check("t4_read_held", 64'({rd_bad, wr_seen}), 64'd0);
    check("t4_wdata_zero", 64'({wnz, 4'(nd)}), 64'd0);

    // 5: split during the second word of a three-word burst
    do_reset();
    s_ready = 3'b001;
    issue(3'b011, 12'd3, 12'h3C5, 2'd0);
    start_mon(1'b1);
    wait_cyc(7);
    split_en = 1'b1; bus_grant = 1'b0;
    tick();
    check("t5_split_state", 64'({so4, br4, bu4, mv4}), 64'b1000);
    tick(); tick();
    split_en = 1'b0;
    tick();
    check("t5_rereq", 64'({so4, br4, bu4}), 64'b010);
    tick();
    bus_grant = 1'b1;
    check("t5_resume_wait", 64'(res_cyc), 64'd0);
    begin
      int gcyc;
      gcyc = cyc;
      wait_tx(30);
      tick();
      check("t5_resume_latency", 64'(res_cyc), 64'(gcyc + 2));
    end
    check("t5_addr_once", 64'(na), 64'd3);
    check("t5_data", data_s, 64'hAFB9A9);
    check("t5_new_data", 64'(n_new), 64'd3);
    check("t5_tx_count", 64'(n_tx), 64'd1);

    // 6a: grant lost mid-DATA aborts without tx_done
    do_reset();
    s_ready = 3'b001;
    issue(3'b011, 12'd3, 12'h3C5, 2'd0);
    start_mon(1'b1);
    wait_cyc(6);
    bus_grant = 1'b0;
    tick();
    check("t6_abort_outs", 64'(outs4), 64'd0);
    repeat (10) tick();
    check("t6_abort_no_tx", 64'(n_tx), 64'd0);

    // 6b: reset mid-DATA, then a normal single read
    do_reset();
    s_ready = 3'b001;
    issue(3'b011, 12'd3, 12'h3C5, 2'd0);
    start_mon(1'b1);
    wait_cyc(6);
    rst_n = 1'b0;
    tick();
    check("t6_reset_outs", 64'(outs4), 64'd0);
    rst_n = 1'b1; bus_grant = 1'b0; mon_en = 1'b0;
    tick();
    issue(3'b010, 12'd0, 12'h123, 2'd0);
    start_mon(1'b1);
    wait_tx(20);
    tick();
    check("t6_read_addr", addr_s, 64'h123);
    check("t6_read_tx_cyc", 64'(tx_cyc), 64'd5);
    check("t6_read_held", 64'({rd_bad, wr_seen}), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
